text_fetch_bus: RTL and testbench



---
 rtl/text_fetch_bus_pkg.sv | 26 ++
 rtl/text_fetch_bus_fifo.sv | 43 ++++
 rtl/text_fetch_bus.sv | 125 ++++++++++++
 tb/tb_text_fetch_bus.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_fetch_bus_pkg.sv
// Shared configuration for the text fetch bus: memory map, default timing and the text ROM image.
package rv_config;
  localparam logic [31:0] TEXT_BEGIN = 32'h0001_0000;
  localparam int          TEXT_BITS  = 8;
  localparam int          READ_LAT   = 2;
  localparam int          FIFO_DEPTH = 4;

  // Program text as 32-bit words; words past the boot stub hold an index-derived pattern.
  function automatic logic [31:0] text_rom_word(input logic [15:0] idx);
    logic [31:0] word;
    case (idx)
      16'd0:   word = 32'h0000_0013;
      16'd1:   word = 32'h0050_0113;
      16'd2:   word = 32'h00A0_0093;
      16'd3:   word = 32'h0020_81B3;
      16'd4:   word = 32'h0000_006F;
      default: word = {idx, ~idx};
    endcase
    return word;
  endfunction
endpackage

package constants;
  localparam int DATA_W_32 = 32;
  localparam int DATA_W_64 = 64;
endpackage

// File: rtl/text_fetch_bus_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push and pop may coincide at any occupancy.
module text_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; every read is qualified by the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/text_fetch_bus.sv
// Pipelined, credit-limited program-text fetch bus with in-order responses.
// Define TEXT_FETCH_FAULT_EN to add the resp_fault output for out-of-range/misaligned fetches.
module text_fetch_bus #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = constants::DATA_W_32,
  parameter logic [ADDR_W-1:0] TEXT_BEGIN = rv_config::TEXT_BEGIN,
  parameter int                TEXT_BITS  = rv_config::TEXT_BITS,
  parameter int                READ_LAT   = rv_config::READ_LAT,
  parameter int                FIFO_DEPTH = rv_config::FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data
`ifdef TEXT_FETCH_FAULT_EN
  ,
  output logic              resp_fault
`endif
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = TEXT_BITS - OFF_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef TEXT_FETCH_FAULT_EN
  localparam int FIFO_W = DATA_W + 1;
`else
  localparam int FIFO_W = DATA_W;
`endif
  // Range compare runs one bit wider so the last text address cannot wrap.
  localparam logic [ADDR_W:0] TEXT_LAST =
    {1'b0, TEXT_BEGIN} + (ADDR_W+1)'((64'd1 << TEXT_BITS) - 64'd1);

  typedef struct packed {
    logic              valid;
    logic [FIFO_W-1:0] payload;
  } stage_t;

  logic              accept;
  logic              consume;
  logic [CNT_W-1:0]  credits;
  logic [ADDR_W:0]   addr_x;
  logic              req_bad;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] rom_word;
  logic [DATA_W-1:0] req_data;
  stage_t            stage_in;
  stage_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_rdata;

  assign req_ready  = (credits < CNT_W'(FIFO_DEPTH)) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = !fifo_empty && !reset;
  assign consume    = resp_valid && resp_ready;

  assign addr_x   = {1'b0, req_addr};
  assign req_bad  = (addr_x < {1'b0, TEXT_BEGIN}) || (addr_x > TEXT_LAST) ||
                    (|req_addr[OFF_W-1:0]);
  assign word_idx = IDX_W'((req_addr - TEXT_BEGIN) >> OFF_W);

  generate
    if (DATA_W == constants::DATA_W_64) begin : g_rom64
      assign rom_word = {rv_config::text_rom_word(16'({word_idx, 1'b1})),
                         rv_config::text_rom_word(16'({word_idx, 1'b0}))};
    end else begin : g_rom32
      assign rom_word = rv_config::text_rom_word(16'(word_idx));
    end
  endgenerate

  assign req_data       = req_bad ? '0 : rom_word;
  assign stage_in.valid = accept;
`ifdef TEXT_FETCH_FAULT_EN
  assign stage_in.payload = {req_bad, req_data};
`else
  assign stage_in.payload = req_data;
`endif

  // READ_LAT-1 registers (the first is the ROM read) so the FIFO write lands in cycle t+READ_LAT-1.
  generate
    if (READ_LAT == 1) begin : g_lat1
      assign head = stage_in;
    end else begin : g_pipe
      stage_t pipe [READ_LAT-1];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < READ_LAT - 1; i++) pipe[i].valid <= 1'b0;
        end else begin
          pipe[0] <= stage_in;
          for (int i = 1; i < READ_LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign head = pipe[READ_LAT-2];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset)                   credits <= '0;
    else if (accept && !consume) credits <= credits + CNT_W'(1);
    else if (consume && !accept) credits <= credits - CNT_W'(1);
  end

  text_fetch_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (head.valid),
    .wdata (head.payload),
    .pop   (consume),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs are gated to zero whenever no response is presented, so they are never X.
  assign resp_data = resp_valid ? fifo_rdata[DATA_W-1:0] : '0;
`ifdef TEXT_FETCH_FAULT_EN
  assign resp_fault = resp_valid && fifo_rdata[DATA_W];
`endif
endmodule

// File: tb/tb_text_fetch_bus.sv
// Self-checking bench for text_fetch_bus: scoreboard model of the bus plus directed scenarios.
module tb_text_fetch_bus;
  import rv_config::*;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] SPAN  = 32'd1 << TEXT_BITS;

  logic        clock      = 1'b0;
  logic        reset      = 1'b1;
  logic        req_valid  = 1'b0;
  logic [31:0] req_addr   = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
`ifdef TEXT_FETCH_FAULT_EN
  logic        resp_fault;
`endif

  text_fetch_bus #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TEXT_BEGIN (TEXT_BEGIN),
    .TEXT_BITS  (TEXT_BITS),
    .READ_LAT   (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
`ifdef TEXT_FETCH_FAULT_EN
    ,
    .resp_fault (resp_fault)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  logic obs_accept;
  logic obs_consume;

  function automatic logic [31:0] rom_ref(input int w);
    logic [15:0] i16;
    i16 = w[15:0];
    case (w)
      0:       return 32'h0000_0013;
      1:       return 32'h0050_0113;
      2:       return 32'h00A0_0093;
      3:       return 32'h0020_81B3;
      4:       return 32'h0000_006F;
      default: return {i16, ~i16};
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] a, input int due);
    exp_t   e;
    longint off;
    off     = longint'(a) - longint'(TEXT_BEGIN);
    e.fault = (off < 0) || (off >= longint'(SPAN)) || (a[1:0] != 2'b00);
    e.data  = e.fault ? 32'h0 : rom_ref(int'(off / 4));
    e.due   = due;
    return e;
  endfunction

  function automatic logic [31:0] aligned_addr();
    return TEXT_BEGIN + 32'd4 * $urandom_range(0, int'(SPAN / 4) - 1);
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return TEXT_BEGIN - 32'd4 * $urandom_range(1, 4);
      1:       return TEXT_BEGIN + SPAN + 32'd4 * $urandom_range(0, 3);
      2:       return aligned_addr() + $urandom_range(1, 3);
      default: return aligned_addr();
    endcase
  endfunction

  // One bus cycle: drive after the edge, sample at the falling edge, advance the scoreboard.
  task automatic bus_cycle(input logic v, input logic [31:0] a, input logic rr, input logic rst);
    logic exp_ready;
    logic exp_valid;
    @(posedge clock);
    cyc++;
    #1;
    reset = rst; req_valid = v; req_addr = a; resp_ready = rr;
    @(negedge clock);
    exp_ready   = !rst && (exp_q.size() < DEPTH);
    exp_valid   = !rst && (exp_q.size() > 0) && (cyc >= exp_q[0].due);
    obs_accept  = req_valid && req_ready;
    obs_consume = resp_valid && resp_ready;
    checks++;
    if (req_ready !== exp_ready) begin
      failures++;
      $display("FAIL req_ready cyc=%0d got=%b expected=%b", cyc, req_ready, exp_ready);
    end
    checks++;
    if (resp_valid !== exp_valid) begin
      failures++;
      $display("FAIL resp_valid cyc=%0d got=%b expected=%b", cyc, resp_valid, exp_valid);
    end
    if (exp_valid && resp_valid === 1'b1) begin
      checks++;
      if (resp_data !== exp_q[0].data) begin
        failures++;
        $display("FAIL resp_data cyc=%0d got=%h expected=%h", cyc, resp_data, exp_q[0].data);
      end
`ifdef TEXT_FETCH_FAULT_EN
      checks++;
      if (resp_fault !== exp_q[0].fault) begin
        failures++;
        $display("FAIL resp_fault cyc=%0d got=%b expected=%b", cyc, resp_fault, exp_q[0].fault);
      end
`endif
    end
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rr) void'(exp_q.pop_front());
      if (v && exp_ready) exp_q.push_back(model(a, cyc + LAT));
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      bus_cycle($urandom_range(0, 1) == 1, rand_addr(), 1'b1, 1'b1);
      checks++;
      if (resp_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_data got=%h expected=00000000", resp_data);
      end
    end
    bus_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after got=%b expected=1", req_ready);
    end
  endtask

  task automatic test_single();
    int t0;
    int seen;
    bus_cycle(1'b1, TEXT_BEGIN + 32'h8, 1'b1, 1'b0);
    t0   = cyc;
    seen = -1;
    for (int i = 0; i < 8 && seen < 0; i++) begin
      bus_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      if (resp_valid === 1'b1) begin
        seen = cyc;
        checks++;
        if (resp_data !== 32'h00A0_0093) begin
          failures++;
          $display("FAIL single_data got=%h expected=00a00093", resp_data);
        end
      end
    end
    checks++;
    if (seen != t0 + LAT) begin
      failures++;
      $display("FAIL single_latency got=%0d expected=%0d", seen - t0, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    int resps = 0;
    int first = -1;
    int last  = -1;
    for (int i = 0; i < 8 + 6; i++) begin
      bus_cycle(i < 8, aligned_addr(), 1'b1, 1'b0);
      if (i < 8 && !obs_accept) drops++;
      if (obs_consume) begin
        resps++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    checks++;
    if (drops != 0) begin
      failures++;
      $display("FAIL b2b_ready_drops got=%0d expected=0", drops);
    end
    checks++;
    if (resps != 8 || last - first != 7) begin
      failures++;
      $display("FAIL b2b_responses got=%0d span=%0d expected=8 span=7", resps, last - first);
    end
  endtask

  task automatic test_backpressure();
    int acc  = 0;
    int cons = 0;
    for (int i = 0; i < 7; i++) begin
      bus_cycle(1'b1, aligned_addr(), 1'b0, 1'b0);
      if (obs_accept) acc++;
    end
    checks++;
    if (acc != DEPTH || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accepted got=%0d ready=%b expected=%0d ready=0", acc, req_ready, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      if (obs_consume) cons++;
      if (i == 1) begin
        checks++;
        if (req_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_ready_return got=%b expected=1", req_ready);
        end
      end
    end
    checks++;
    if (cons != DEPTH) begin
      failures++;
      $display("FAIL bp_drain got=%0d expected=%0d", cons, DEPTH);
    end
  endtask

  task automatic test_bad_addresses();
    logic [31:0] addrs [7];
    logic [31:0] want  [7];
    logic        wflt  [7];
    int          n = 0;
    addrs = '{TEXT_BEGIN - 32'd4, TEXT_BEGIN + 32'h8, TEXT_BEGIN + SPAN, TEXT_BEGIN + 32'hC,
              TEXT_BEGIN + 32'h2, TEXT_BEGIN + SPAN - 32'd4, TEXT_BEGIN + 32'h4};
    want  = '{32'h0, 32'h00A0_0093, 32'h0, 32'h0020_81B3, 32'h0, 32'h003F_FFC0, 32'h0050_0113};
    wflt  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7 + 6; i++) begin
      bus_cycle(i < 7, (i < 7) ? addrs[i] : 32'h0, 1'b1, 1'b0);
      if (obs_consume && n < 7) begin
        checks++;
        if (resp_data !== want[n]) begin
          failures++;
          $display("FAIL bad_seq_data[%0d] got=%h expected=%h", n, resp_data, want[n]);
        end
`ifdef TEXT_FETCH_FAULT_EN
        checks++;
        if (resp_fault !== wflt[n]) begin
          failures++;
          $display("FAIL bad_seq_fault[%0d] got=%b expected=%b", n, resp_fault, wflt[n]);
        end
`else
        if (wflt[n] && resp_data !== 32'h0) $display("bad fetch %0d returned nonzero", n);
`endif
        n++;
      end
    end
    checks++;
    if (n != 7) begin
      failures++;
      $display("FAIL bad_seq_count got=%0d expected=7", n);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      bus_cycle($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0, 1'b0);
    for (int i = 0; i < 10; i++) bus_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL random_drain valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_inflight();
    int n = 0;
    for (int i = 0; i < 3; i++) bus_cycle(1'b1, aligned_addr(), 1'b0, 1'b0);
    bus_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    bus_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL inflight_reset valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready);
    end
    bus_cycle(1'b1, TEXT_BEGIN + 32'h4, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      if (obs_consume) begin
        n++;
        checks++;
        if (resp_data !== 32'h0050_0113) begin
          failures++;
          $display("FAIL inflight_fresh_data got=%h expected=00500113", resp_data);
        end
      end
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL inflight_fresh_count got=%0d expected=1", n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_bad_addresses();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
